cfi_alert_unit: RTL and testbench

Response stage downstream of the commit-stage CFI checker. Takes per-commit-port violation pulses (forward-edge landing-pad miss, return mismatch) and turns them into a PC/cause log FIFO drained by software or debug logic, a saturating violation counter, an interrupt with acknowledge handshake, and a threshold-based halt request to the core's controller.

---
 rtl/cfi_alert_unit_if.sv | 29 ++
 rtl/cfi_alert_unit.sv | 138 +++++++++++++
 tb/tb_cfi_alert_unit.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/cfi_alert_unit_if.sv
// Port bundle for cfi_alert_unit: violation inputs, log FIFO drain, IRQ handshake and status.
interface cfi_alert_unit_if #(
  parameter int unsigned NR_PORTS = 2,
  parameter int unsigned PC_W     = 64
);
  logic [NR_PORTS-1:0]           viol_valid_i;
  logic [NR_PORTS-1:0][PC_W-1:0] viol_pc_i;
  logic [NR_PORTS-1:0][1:0]      viol_cause_i;
  logic                          log_valid_o;
  logic [PC_W-1:0]               log_pc_o;
  logic [1:0]                    log_cause_o;
  logic                          log_ready_i;
  logic                          irq_o;
  logic                          irq_ack_i;
  logic                          halt_o;
  logic                          clear_i;
  logic [7:0]                    viol_count_o;
  logic                          overflow_o;

  modport master (
    output viol_valid_i, viol_pc_i, viol_cause_i, log_ready_i, irq_ack_i, clear_i,
    input  log_valid_o, log_pc_o, log_cause_o, irq_o, halt_o, viol_count_o, overflow_o
  );

  modport slave (
    input  viol_valid_i, viol_pc_i, viol_cause_i, log_ready_i, irq_ack_i, clear_i,
    output log_valid_o, log_pc_o, log_cause_o, irq_o, halt_o, viol_count_o, overflow_o
  );
endinterface

// File: rtl/cfi_alert_unit.sv
// CFI violation response: PC/cause log FIFO, saturating counter, IRQ handshake and
// threshold halt request.
module cfi_alert_unit #(
  parameter int unsigned NR_PORTS  = 2,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned THRESHOLD = 3,
  parameter int unsigned PC_W      = 64
) (
  input logic             clk_i,
  input logic             rst_i,
  cfi_alert_unit_if.slave bus
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;

  typedef enum logic [1:0] {StIdle, StPend, StAcked} irq_state_e;

  logic [PC_W-1:0] pc_q    [DEPTH];
  logic [1:0]      cause_q [DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PtrW-1:0] occupancy, free_slots, push_cnt;
  logic            fifo_empty, pop, drop;

  logic [NR_PORTS-1:0] wr_en;
  logic [AddrW-1:0]    wr_addr [NR_PORTS];

  logic [15:0] n_viol, count_sum;
  logic [7:0]  count_q, count_d, count_base;
  logic        halt_q, halt_d;
  logic        overflow_q, overflow_d;

  irq_state_e state_q, state_d;

  // Pointers carry an extra wrap bit so full and empty differ.
  assign occupancy  = wptr_q - rptr_q;
  assign free_slots = PtrW'(DEPTH) - occupancy;
  assign fifo_empty = (wptr_q == rptr_q);
  assign pop        = !fifo_empty && bus.log_ready_i;

  // Ports claim free slots in ascending order; space freed by a same-cycle pop is not reused.
  always_comb begin
    push_cnt = '0;
    drop     = 1'b0;
    wr_en    = '0;
    n_viol   = '0;
    for (int p = 0; p < NR_PORTS; p++) begin
      wr_addr[p] = '0;
      if (bus.viol_valid_i[p]) begin
        n_viol = n_viol + 16'd1;
        if (push_cnt < free_slots) begin
          wr_en[p]   = 1'b1;
          wr_addr[p] = wptr_q[AddrW-1:0] + push_cnt[AddrW-1:0];
          push_cnt   = push_cnt + PtrW'(1);
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  assign wptr_d = wptr_q + push_cnt;
  assign rptr_d = rptr_q + PtrW'(pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        cause_q[i] <= '0;
      end
    end else begin
      for (int p = 0; p < NR_PORTS; p++) begin
        if (wr_en[p]) begin
          pc_q[wr_addr[p]]    <= bus.viol_pc_i[p];
          cause_q[wr_addr[p]] <= bus.viol_cause_i[p];
        end
      end
    end
  end

  // Counter, halt and overflow; dropped violations still count.
  always_comb begin
    count_base = bus.clear_i ? 8'd0 : count_q;
    count_sum  = {8'd0, count_base} + n_viol;
    count_d    = (count_sum > 16'd255) ? 8'hff : count_sum[7:0];
    halt_d     = ({8'd0, count_d} >= 16'(THRESHOLD));
    overflow_d = (overflow_q && !bus.clear_i) || drop;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      halt_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      halt_q     <= halt_d;
      overflow_q <= overflow_d;
    end
  end

  // IRQ FSM: state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // IRQ FSM: next state. ACKED lasts one cycle so irq_o visibly drops before re-raising.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (n_viol != 16'd0) state_d = StPend;
      StPend:  if (bus.irq_ack_i) state_d = StAcked;
      StAcked: state_d = (!fifo_empty || n_viol != 16'd0) ? StPend : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // IRQ FSM: outputs.
  always_comb begin
    bus.irq_o = (state_q == StPend);
  end

  assign bus.log_valid_o  = !fifo_empty;
  assign bus.log_pc_o     = fifo_empty ? '0 : pc_q[rptr_q[AddrW-1:0]];
  assign bus.log_cause_o  = fifo_empty ? '0 : cause_q[rptr_q[AddrW-1:0]];
  assign bus.viol_count_o = count_q;
  assign bus.halt_o       = halt_q;
  assign bus.overflow_o   = overflow_q;

endmodule

// File: tb/tb_cfi_alert_unit.sv
// Directed self-checking bench for cfi_alert_unit (NR_PORTS=2, DEPTH=4, THRESHOLD=2).
module tb_cfi_alert_unit;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  cfi_alert_unit_if #(.NR_PORTS(2), .PC_W(64)) vif ();

  cfi_alert_unit #(
    .NR_PORTS (2),
    .DEPTH    (4),
    .THRESHOLD(2),
    .PC_W     (64)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (vif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    vif.viol_valid_i = '0;
    vif.viol_pc_i    = '0;
    vif.viol_cause_i = '0;
    vif.log_ready_i  = 1'b0;
    vif.irq_ack_i    = 1'b0;
    vif.clear_i      = 1'b0;
  endtask

  // Reset pulse placed between clock edges.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  // One clock of violations; inputs go back to idle afterwards.
  task automatic viol(input logic v0, input logic [63:0] pc0, input logic [1:0] c0,
                      input logic v1, input logic [63:0] pc1, input logic [1:0] c1);
    vif.viol_valid_i    = {v1, v0};
    vif.viol_pc_i[0]    = pc0;
    vif.viol_pc_i[1]    = pc1;
    vif.viol_cause_i[0] = c0;
    vif.viol_cause_i[1] = c1;
    tick();
    idle_inputs();
  endtask

  task automatic pop_one();
    vif.log_ready_i = 1'b1;
    tick();
    vif.log_ready_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 64'(vif.log_valid_o), 64'd0);
    check({tag, "_pc"}, vif.log_pc_o, 64'd0);
    check({tag, "_cause"}, 64'(vif.log_cause_o), 64'd0);
    check({tag, "_irq"}, 64'(vif.irq_o), 64'd0);
    check({tag, "_halt"}, 64'(vif.halt_o), 64'd0);
    check({tag, "_count"}, 64'(vif.viol_count_o), 64'd0);
    check({tag, "_ovf"}, 64'(vif.overflow_o), 64'd0);
  endtask

  logic [63:0] exp_pcs [4];

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;

    // Single violation on port 0.
    viol(1'b1, 64'h8000_0100, 2'd0, 1'b0, 64'd0, 2'd0);
    check("single_valid", 64'(vif.log_valid_o), 64'd1);
    check("single_pc", vif.log_pc_o, 64'h8000_0100);
    check("single_count", 64'(vif.viol_count_o), 64'd1);
    check("single_irq", 64'(vif.irq_o), 64'd1);
    check("single_halt", 64'(vif.halt_o), 64'd0);

    // Both ports in one cycle, ascending order, threshold reached.
    do_reset();
    viol(1'b1, 64'h100, 2'd0, 1'b1, 64'h104, 2'd1);
    check("dual_count", 64'(vif.viol_count_o), 64'd2);
    check("dual_halt", 64'(vif.halt_o), 64'd1);
    check("dual_pc0", vif.log_pc_o, 64'h100);
    check("dual_cause0", 64'(vif.log_cause_o), 64'd0);
    pop_one();
    check("dual_pc1", vif.log_pc_o, 64'h104);
    check("dual_cause1", 64'(vif.log_cause_o), 64'd1);
    pop_one();
    check("dual_empty", 64'(vif.log_valid_o), 64'd0);
    check("dual_empty_pc", vif.log_pc_o, 64'd0);

    // Fill, then drop two with a simultaneous pop.
    do_reset();
    viol(1'b1, 64'h200, 2'd0, 1'b1, 64'h204, 2'd1);
    viol(1'b1, 64'h208, 2'd0, 1'b1, 64'h20c, 2'd1);
    check("fill_count", 64'(vif.viol_count_o), 64'd4);
    check("fill_ovf", 64'(vif.overflow_o), 64'd0);
    vif.log_ready_i = 1'b1;
    viol(1'b1, 64'h300, 2'd0, 1'b1, 64'h304, 2'd0);
    check("drop_ovf", 64'(vif.overflow_o), 64'd1);
    check("drop_count", 64'(vif.viol_count_o), 64'd6);
    check("drop_head", vif.log_pc_o, 64'h204);

    // Clear alone leaves FIFO intact.
    vif.clear_i = 1'b1;
    tick();
    vif.clear_i = 1'b0;
    check("clr_count", 64'(vif.viol_count_o), 64'd0);
    check("clr_halt", 64'(vif.halt_o), 64'd0);
    check("clr_ovf", 64'(vif.overflow_o), 64'd0);
    check("clr_head", vif.log_pc_o, 64'h204);

    // One free slot: port 0 logged, port 1 dropped.
    viol(1'b1, 64'h400, 2'd3, 1'b1, 64'h404, 2'd0);
    check("part_ovf", 64'(vif.overflow_o), 64'd1);
    check("part_count", 64'(vif.viol_count_o), 64'd2);
    check("part_halt", 64'(vif.halt_o), 64'd1);
    exp_pcs[0] = 64'h204;
    exp_pcs[1] = 64'h208;
    exp_pcs[2] = 64'h20c;
    exp_pcs[3] = 64'h400;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("part_drain%0d", i), vif.log_pc_o, exp_pcs[i]);
      pop_one();
    end
    check("part_empty", 64'(vif.log_valid_o), 64'd0);

    // IRQ handshake.
    do_reset();
    viol(1'b1, 64'h500, 2'd1, 1'b0, 64'd0, 2'd0);
    check("irq_set", 64'(vif.irq_o), 64'd1);
    vif.irq_ack_i = 1'b1;
    tick();
    vif.irq_ack_i = 1'b0;
    check("irq_acked", 64'(vif.irq_o), 64'd0);
    tick();
    check("irq_reraise", 64'(vif.irq_o), 64'd1);
    pop_one();
    check("irq_hold", 64'(vif.irq_o), 64'd1);
    vif.irq_ack_i = 1'b1;
    tick();
    vif.irq_ack_i = 1'b0;
    check("irq_ack2", 64'(vif.irq_o), 64'd0);
    tick();
    check("irq_idle", 64'(vif.irq_o), 64'd0);
    vif.irq_ack_i = 1'b1;
    tick();
    vif.irq_ack_i = 1'b0;
    check("irq_ack_idle", 64'(vif.irq_o), 64'd0);

    // Saturation at 255.
    do_reset();
    for (int i = 0; i < 128; i++) begin
      viol(1'b1, 64'h1000 + 64'(8 * i), 2'd0, 1'b1, 64'h1004 + 64'(8 * i), 2'd1);
    end
    check("sat_count", 64'(vif.viol_count_o), 64'd255);
    viol(1'b1, 64'h2000, 2'd0, 1'b0, 64'd0, 2'd0);
    check("sat_hold", 64'(vif.viol_count_o), 64'd255);
    check("sat_ovf", 64'(vif.overflow_o), 64'd1);
    vif.clear_i = 1'b1;
    tick();
    vif.clear_i = 1'b0;
    check("sat_clr_count", 64'(vif.viol_count_o), 64'd0);
    check("sat_clr_halt", 64'(vif.halt_o), 64'd0);
    check("sat_clr_ovf", 64'(vif.overflow_o), 64'd0);
    check("sat_clr_head", vif.log_pc_o, 64'h1000);
    vif.clear_i = 1'b1;
    viol(1'b1, 64'h3000, 2'd0, 1'b1, 64'h3004, 2'd0);
    check("clrv_count", 64'(vif.viol_count_o), 64'd2);
    check("clrv_halt", 64'(vif.halt_o), 64'd1);
    check("clrv_ovf", 64'(vif.overflow_o), 64'd1);

    // Asynchronous reset mid-burst.
    do_reset();
    viol(1'b1, 64'h600, 2'd0, 1'b1, 64'h604, 2'd0);
    viol(1'b1, 64'h608, 2'd0, 1'b0, 64'd0, 2'd0);
    check("pre_rst_irq", 64'(vif.irq_o), 64'd1);
    vif.viol_valid_i = 2'b11;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    #1;
    rst = 1'b0;
    idle_inputs();
    viol(1'b0, 64'd0, 2'd0, 1'b1, 64'h700, 2'd2);
    check("post_rst_pc", vif.log_pc_o, 64'h700);
    check("post_rst_cause", 64'(vif.log_cause_o), 64'd2);
    check("post_rst_count", 64'(vif.viol_count_o), 64'd1);
    pop_one();
    check("post_rst_sole", 64'(vif.log_valid_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
